dma_write_control: RTL and testbench
====================================

Name: dma_write_control

Overview:
- AXI4-Lite master that drains a word stream from the accelerator and writes it to DDR, one 32-bit single-beat write per word, starting at a programmed destination address.
- It is the write-direction counterpart of the DMA read control block.
- Sits between the accelerator output buffer and the PS/DDR HP port.
- It is configured by a start pulse and reports completion with an interrupt pulse and an idle flag.

Parameters:
- C_M00_AXI_ADDR_WIDTH, 32, AXI address width; only 32 is supported.
- C_M00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M00_AXI_AWPROT, 3'b000, constant driven on m00_axi_awprot.

Ports:
- m00_axi_aclk  in  1  sole clock.
- m00_axi_aresetn  in  1  reset: asynchronous, active-low.
- dma_da_config  in  32  destination byte address; sampled at start.
- dma_length_config  in  26  transfer length in bytes; sampled at start; bits [1:0] are ignored.
- dma_write_start  in  1  one-cycle start request.
- dma_wdata  in  32  stream data word.
- dma_wdata_valid  in  1  stream valid.
- dma_wdata_ready  out  1  stream ready.
- dma_write_irq  out  1  one-cycle completion pulse.
- dma_write_err  out  1  sticky flag: at least one BRESP was not OKAY.
- dma_idle  out  1  high when the block can accept a start.
- m00_axi_awaddr/awprot/awvalid/awready  AXI-Lite write-address channel (out/out/out/in).
- m00_axi_wdata/wstrb/wvalid/wready  AXI-Lite write-data channel (out/out/out/in).
- m00_axi_bresp/bvalid/bready  AXI-Lite write-response channel (in/in/out).
- m00_axi_araddr/arprot/arvalid/arready/rdata/rresp/rvalid/rready  AXI-Lite read channels; unused. Outputs are tied: araddr=0, arprot=0, arvalid=0, rready=0.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - awvalid, wvalid, bready, dma_wdata_ready, dma_write_irq and dma_write_err are 0.
  - awaddr and wdata are 0; dma_idle is 1.
  - Reset mid-transfer abandons the transfer with no irq.
- wstrb is constantly 4'hF. awprot is C_M00_AXI_AWPROT.
- Registers:
  - addr_r (32b): destination address.
  - remain_r (24b): words left, loaded with dma_length_config[25:2].
  - aw_done and w_done flags.
- FSM states:
  - IDLE: dma_idle=1.
    - dma_write_start=1 → load addr_r and remain_r, clear dma_write_err.
    - Next state is DONE if remain_r would be 0, else FETCH.
    - Start in any other state is ignored.
  - FETCH: dma_wdata_ready=1 (combinational from state).
    - On valid&&ready: latch wdata, drive awaddr=addr_r, go to WRITE.
    - awvalid and wvalid rise in the next cycle.
  - WRITE: awvalid and wvalid are driven independently.
    - awvalid drops the cycle after awready is sampled high; set aw_done.
    - wvalid drops the cycle after wready is sampled high; set w_done.
    - Either handshake order, or both in the same cycle, is legal.
    - When both are done, go to RESP and clear the flags.
    - awaddr and wdata stay stable while their valid is high.
  - RESP: bready=1.
    - On bvalid: if bresp≠2'b00, set dma_write_err (sticky).
    - addr_r += 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
    - remain_r -= 1.
    - Next state is DONE if the new remain_r is 0, else FETCH.
  - DONE: dma_write_irq=1 for exactly one cycle, dma_idle=0. Next state is IDLE.
- Exactly one outstanding write at a time; no new AW or W is issued before B completes.
- Length of 0 (or 1..3 bytes): the irq pulse arrives 1 cycle after the start with no AXI activity.
- Throughput with zero-wait slave and always-valid stream: 4 cycles per word (FETCH, WRITE, RESP, then back to FETCH).
- An error response does not abort the transfer. dma_write_err holds until the next accepted start.
- Stream data offered while not in FETCH is not consumed, because ready is 0.

Test Plan:
- Basic write:
  - Stimulus: da=0x1000_0000, length=16, stream 0xA0..0xA3 always valid, zero-wait slave.
  - Required: 4 writes to 0x1000_0000/04/08/0C with data A0..A3, wstrb=F; one irq pulse; idle high after; err=0.
- AW/W skew:
  - Stimulus: awready delayed 3 cycles, wready immediate.
  - Required: wvalid drops after 1 cycle; awvalid holds with a stable address until its handshake; bready only after both handshakes; data is correct.
- Zero length:
  - Stimulus: length=0, then length=3.
  - Required: irq pulses 1 cycle after each start; awvalid never asserts; dma_wdata_ready stays 0.
- Error response and wrap:
  - Stimulus: da=0xFFFF_FFF8, length=12; BRESP=2'b10 on the 2nd write.
  - Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; all 3 writes performed; err=1 at irq; err cleared by the next start.
- Stream stall and reset:
  - Stimulus: stream valid gapped by 5 cycles between words.
  - Required: ready is held with no duplicate or dropped word.
  - Stimulus: aresetn asserted while in RESP.
  - Required: all valids/readys and irq go 0 immediately, idle=1; a new start after release completes normally.
- Start while busy:
  - Stimulus: second start pulse during WRITE.
  - Required: ignored; the original transfer completes with the original address and length; exactly one irq.

Source files
------------

// File: rtl/dma_write_control_if.sv
// rtl/dma_write_control_if.sv - AXI4-Lite bus bundle between the DMA write control block and the HP port
interface dma_write_control_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32
) ();
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/dma_write_control.sv
// rtl/dma_write_control.sv - AXI4-Lite master draining a word stream into DDR, one single-beat write per word
module dma_write_control #(
  parameter int         C_M00_AXI_ADDR_WIDTH = 32,
  parameter int         C_M00_AXI_DATA_WIDTH = 32,
  parameter logic [2:0] C_M00_AXI_AWPROT     = 3'b000
) (
  input  logic                m00_axi_aclk,
  input  logic                m00_axi_aresetn,
  input  logic [31:0]         dma_da_config,
  input  logic [25:0]         dma_length_config,
  input  logic                dma_write_start,
  input  logic [31:0]         dma_wdata,
  input  logic                dma_wdata_valid,
  output logic                dma_wdata_ready,
  output logic                dma_write_irq,
  output logic                dma_write_err,
  output logic                dma_idle,
  dma_write_control_if.master m00_axi
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                            r_state;
  state_t                            w_next_state;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [23:0]                       r_remain;
  logic                              r_aw_done;
  logic                              r_w_done;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_err;
  logic                              w_bready;
  logic [23:0]                       w_len_words;
  logic                              w_unused_ok;

  // Byte length rounded down to whole words; partial trailing bytes are dropped
  assign w_len_words = dma_length_config[25:2];

  assign m00_axi.awaddr  = r_awaddr;
  assign m00_axi.awprot  = C_M00_AXI_AWPROT;
  assign m00_axi.awvalid = r_awvalid;
  assign m00_axi.wdata   = r_wdata;
  assign m00_axi.wstrb   = '1;
  assign m00_axi.wvalid  = r_wvalid;
  assign m00_axi.bready  = w_bready;
  assign m00_axi.araddr  = '0;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = 1'b0;
  assign m00_axi.rready  = 1'b0;
  assign dma_write_err   = r_err;

  assign w_unused_ok = ^{dma_length_config[1:0], m00_axi.arready, m00_axi.rdata,
                         m00_axi.rresp, m00_axi.rvalid};

  // State register
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived handshake/status outputs
  always_comb begin
    w_next_state    = r_state;
    dma_wdata_ready = 1'b0;
    w_bready        = 1'b0;
    dma_write_irq   = 1'b0;
    dma_idle        = 1'b0;
    case (r_state)
      S_IDLE: begin
        dma_idle = 1'b1;
        if (dma_write_start) begin
          w_next_state = (w_len_words == 24'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        dma_wdata_ready = 1'b1;
        if (dma_wdata_valid) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_aw_done && r_w_done) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (m00_axi.bvalid) begin
          w_next_state = (r_remain == 24'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        dma_write_irq = 1'b1;
        w_next_state  = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Transfer bookkeeping and AW/W channel drive; AW and W retire independently
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dma_write_start) begin
            r_addr   <= dma_da_config;
            r_remain <= w_len_words;
            r_err    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (dma_wdata_valid) begin
            r_wdata   <= dma_wdata;
            r_awaddr  <= r_addr;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_awvalid && m00_axi.awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && m00_axi.wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (r_aw_done && r_w_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_RESP: begin
          if (m00_axi.bvalid) begin
            if (m00_axi.bresp != 2'b00) begin
              r_err <= 1'b1;
            end
            r_addr   <= r_addr + C_M00_AXI_ADDR_WIDTH'(4);
            r_remain <= r_remain - 24'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_control.sv
// tb/tb_dma_write_control.sv - directed self-checking bench for dma_write_control
module tb_dma_write_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] da = '0;
  logic [25:0] len = '0;
  logic        start = 1'b0;
  logic [31:0] sdata = '0;
  logic        svalid = 1'b0;
  logic        sready;
  logic        irq;
  logic        err;
  logic        idle;

  dma_write_control_if bus ();

  dma_write_control dut (
    .m00_axi_aclk      (clk),
    .m00_axi_aresetn   (rst_n),
    .dma_da_config     (da),
    .dma_length_config (len),
    .dma_write_start   (start),
    .dma_wdata         (sdata),
    .dma_wdata_valid   (svalid),
    .dma_wdata_ready   (sready),
    .dma_write_irq     (irq),
    .dma_write_err     (err),
    .dma_idle          (idle),
    .m00_axi           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bench configuration (written by the stimulus process only)
  int          aw_delay = 0;
  int          w_delay = 0;
  int          err_at = -1;
  int          s_n = 0;
  int          s_gap = 0;
  int          s_load = 0;
  logic [31:0] s_words [8];

  // Slave/stream model state (written by the model process only)
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [3:0]  log_strb [64];
  int aw_hs = 0, w_hs = 0, b_cnt = 0, irq_cnt = 0;
  int aw_hi = 0, w_hi = 0, last_aw_hi = 0, last_w_hi = 0;
  int bad_stable = 0, bad_bready = 0, bad_outst = 0;
  int awv_cycles = 0, rdy_cycles = 0;
  int s_idx = 0, s_seen = 0, s_gap_cnt = 0;
  logic [31:0] aw_first = '0, w_first = '0;

  // Slave and stream model: decisions at negedge take effect at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      b_cnt = aw_hs;
      w_hs  = aw_hs;
      aw_hi = 0;
      w_hi  = 0;
    end else begin
      if (irq) irq_cnt++;
      if (bus.awvalid) awv_cycles++;
      if (sready) rdy_cycles++;
      bus.awready = 1'b0;
      if (bus.awvalid) begin
        if (aw_hi == 0) aw_first = bus.awaddr;
        else if (bus.awaddr !== aw_first) bad_stable++;
        if (aw_hi >= aw_delay) begin
          bus.awready = 1'b1;
          if (aw_hs != b_cnt) bad_outst++;
          log_addr[aw_hs % 64] = bus.awaddr;
          aw_hs++;
          last_aw_hi = aw_hi + 1;
          aw_hi = 0;
        end else aw_hi++;
      end else aw_hi = 0;
      bus.wready = 1'b0;
      if (bus.wvalid) begin
        if (w_hi == 0) w_first = bus.wdata;
        else if (bus.wdata !== w_first) bad_stable++;
        if (w_hi >= w_delay) begin
          bus.wready = 1'b1;
          if (w_hs != b_cnt) bad_outst++;
          log_data[w_hs % 64] = bus.wdata;
          log_strb[w_hs % 64] = bus.wstrb;
          w_hs++;
          last_w_hi = w_hi + 1;
          w_hi = 0;
        end else w_hi++;
      end else w_hi = 0;
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
      if (bus.bready) begin
        if (aw_hs <= b_cnt || w_hs <= b_cnt) bad_bready++;
        else begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;
          b_cnt++;
        end
      end
    end
    if (s_load != s_seen) begin
      s_seen = s_load;
      s_idx = 0;
      s_gap_cnt = 0;
    end
    if (s_gap_cnt > 0) begin
      s_gap_cnt--;
      svalid = 1'b0;
    end else if (s_idx < s_n) begin
      svalid = 1'b1;
      sdata  = s_words[s_idx];
      if (sready) begin
        s_idx++;
        s_gap_cnt = s_gap;
      end
    end else svalid = 1'b0;
  end

  int base_aw, base_w, base_b, base_irq, base_awv, base_rdy;
  int lat;
  logic err_irq;

  task automatic snapshot();
    base_aw  = aw_hs;
    base_w   = w_hs;
    base_b   = b_cnt;
    base_irq = irq_cnt;
    base_awv = awv_cycles;
    base_rdy = rdy_cycles;
  endtask

  task automatic load_stream(input int n, input int gap, input logic [31:0] w0);
    for (int i = 0; i < n; i++) s_words[i] = w0 + 32'(i);
    s_n = n;
    s_gap = gap;
    s_load++;
  endtask

  task automatic run_xfer(input logic [31:0] a, input logic [25:0] l, input bit restart);
    bit rs;
    rs = 0;
    @(negedge clk); #1;
    snapshot();
    da = a; len = l; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; da = 32'hDEAD_BEEC; len = 26'h3FF_FFFC;
    lat = 1;
    while (!irq && lat < 2000) begin
      if (restart && !rs && bus.awvalid) begin
        start = 1'b1;
        rs = 1;
      end
      @(negedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("irq_seen", irq, 1'b1);
    err_irq = err;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] a0);
    check({tag, "_naw"}, aw_hs - base_aw, n);
    check({tag, "_nw"}, w_hs - base_w, n);
    check({tag, "_nb"}, b_cnt - base_b, n);
    check({tag, "_irqs"}, irq_cnt - base_irq, 1);
    check({tag, "_idle"}, idle, 1'b1);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr[(base_aw + i) % 64], a0 + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), log_data[(base_w + i) % 64], s_words[i]);
      check($sformatf("%s_strb%0d", tag, i), log_strb[(base_w + i) % 64], 4'hF);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arready = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rvalid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_idle", idle, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sready", sready, 1'b0);
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid", bus.wvalid, 1'b0);
    check("rst_bready", bus.bready, 1'b0);
    check("rst_awaddr", bus.awaddr, 32'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check("rst_wstrb", bus.wstrb, 4'hF);
    check("rst_awprot", bus.awprot, 3'b000);
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_rready", bus.rready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic four-word write
    load_stream(4, 0, 32'hA0);
    run_xfer(32'h1000_0000, 26'd16, 1'b0);
    check_writes("basic", 4, 32'h1000_0000);
    check("basic_err", err, 1'b0);

    // AW handshake delayed, W immediate
    aw_delay = 3;
    load_stream(1, 0, 32'hB0);
    run_xfer(32'h0000_0100, 26'd4, 1'b0);
    check_writes("skew", 1, 32'h0000_0100);
    check("skew_aw_cycles", last_aw_hi, 4);
    check("skew_w_cycles", last_w_hi, 1);
    check("skew_bready_early", bad_bready, 0);
    aw_delay = 0;

    // Zero and sub-word lengths: irq one cycle after start, no bus or stream activity
    load_stream(1, 0, 32'h55);
    run_xfer(32'h0000_2000, 26'd0, 1'b0);
    check("zero0_lat", lat, 1);
    check("zero0_awv", awv_cycles - base_awv, 0);
    check("zero0_rdy", rdy_cycles - base_rdy, 0);
    check("zero0_irqs", irq_cnt - base_irq, 1);
    run_xfer(32'h0000_2000, 26'd3, 1'b0);
    check("zero3_lat", lat, 1);
    check("zero3_awv", awv_cycles - base_awv, 0);
    check("zero3_rdy", rdy_cycles - base_rdy, 0);
    check("zero_stream_kept", s_idx, 0);

    // Error response on the second write plus address wrap
    load_stream(3, 0, 32'hC0);
    err_at = b_cnt + 1;
    run_xfer(32'hFFFF_FFF8, 26'd12, 1'b0);
    check_writes("wrap", 3, 32'hFFFF_FFF8);
    check("wrap_addr2", log_addr[(base_aw + 2) % 64], 32'h0000_0000);
    check("wrap_err_at_irq", err_irq, 1'b1);
    check("wrap_err_sticky", err, 1'b1);
    err_at = -1;
    run_xfer(32'h0000_0000, 26'd0, 1'b0);
    check("err_cleared", err, 1'b0);

    // Gapped stream: every word taken exactly once
    load_stream(3, 5, 32'h11);
    run_xfer(32'h0000_3000, 26'd12, 1'b0);
    check_writes("stall", 3, 32'h0000_3000);
    check("stall_consumed", s_idx, 3);

    // Reset while waiting in the response state
    load_stream(4, 0, 32'hD0);
    @(negedge clk); #1;
    snapshot();
    da = 32'h4000_0000; len = 26'd16; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!bus.bready && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    check("rstmid_reached_resp", bus.bready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_bready", bus.bready, 1'b0);
    check("rstmid_awvalid", bus.awvalid, 1'b0);
    check("rstmid_wvalid", bus.wvalid, 1'b0);
    check("rstmid_sready", sready, 1'b0);
    check("rstmid_irq", irq, 1'b0);
    check("rstmid_idle", idle, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_no_irq", irq_cnt - base_irq, 0);
    load_stream(2, 0, 32'hE0);
    run_xfer(32'h2000_0000, 26'd8, 1'b0);
    check_writes("after_rst", 2, 32'h2000_0000);

    // Start pulse while busy is ignored
    load_stream(2, 0, 32'hF0);
    run_xfer(32'h3000_0000, 26'd8, 1'b1);
    check_writes("busy", 2, 32'h3000_0000);

    check("proto_outstanding", bad_outst, 0);
    check("proto_stable", bad_stable, 0);
    check("proto_bready", bad_bready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
